// File: rtl/sensor_scan_scheduler.sv
// sensor_scan_scheduler
// Shares one change-detect co-processor between four sensor channels.
// A round-robin arbiter grants a ready channel, holds its sample on the
// co-processor inputs for a fixed window, then samples the change flag and
// logs qualifying change events into a small show-ahead event FIFO.

module sensor_scan_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ch_valid,
  input  logic [31:0] ch_data,
  input  logic [3:0]  en_mask,
  output logic [3:0]  ch_ack,
  output logic [7:0]  cop_data,
  output logic [1:0]  cop_check,
  input  logic        cop_q,
  input  logic [1:0]  cop_q1,
  output logic        evt_valid,
  output logic [1:0]  evt_ch,
  output logic [7:0]  evt_data,
  input  logic        evt_ready,
  output logic        overflow,
  output logic        busy
);

  // Hold windows shorter than 3 cycles are stretched to 3; longer than 15
  // cannot be represented by the 4-bit hold counter.
  localparam int HoldEff = (HOLD_CYCLES < 3) ? 3 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
  localparam logic [3:0] HoldLoad = 4'(HoldEff - 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2,
    CHECK = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [3:0]  holdCnt_q, holdCnt_d;
  logic [7:0]  copData_q, copData_d;
  logic [1:0]  copCheck_q, copCheck_d;

  logic [3:0]  req;
  logic        reqAny;
  logic [1:0]  grantCh;
  logic        grantFire;
  logic        pushReq;

  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wrPtr_q, rdPtr_q;
  logic        overflow_q;
  logic        fifoEmpty, fifoFull, doPop, doWrite, doDrop;

  assign req    = ch_valid & en_mask;
  assign reqAny = |req;

  // Round-robin search: first requesting channel after the last granted one.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    found   = 1'b0;
    grantCh = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        grantCh = cand;
      end
    end
  end

  // State register plus the scan datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd3;
      holdCnt_q  <= 4'd0;
      copData_q  <= 8'd0;
      copCheck_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      holdCnt_q  <= holdCnt_d;
      copData_q  <= copData_d;
      copCheck_q <= copCheck_d;
    end
  end

  // Next-state logic; a grant that loses its request falls back to IDLE untouched.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    holdCnt_d  = holdCnt_q;
    copData_d  = copData_q;
    copCheck_d = copCheck_q;
    unique case (state_q)
      IDLE: begin
        if (reqAny) state_d = GRANT;
      end
      GRANT: begin
        if (reqAny) begin
          ptr_d      = grantCh;
          copCheck_d = grantCh;
          copData_d  = ch_data[8*grantCh +: 8];
          holdCnt_d  = HoldLoad;
          state_d    = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (holdCnt_q == 4'd0) begin
          state_d = CHECK;
        end else begin
          holdCnt_d = holdCnt_q - 4'd1;
        end
      end
      CHECK: begin
        state_d = reqAny ? GRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state: ack pulse in GRANT, event push in CHECK.
  always_comb begin
    grantFire = (state_q == GRANT) && reqAny;
    ch_ack    = grantFire ? (4'b0001 << grantCh) : 4'b0000;
    pushReq   = (state_q == CHECK) && cop_q && (cop_q1 == copCheck_q);
    busy      = (state_q != IDLE);
  end

  assign cop_data  = copData_q;
  assign cop_check = copCheck_q;

  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPop     = !fifoEmpty && evt_ready;
  assign doWrite   = pushReq && (!fifoFull || doPop);
  assign doDrop    = pushReq && fifoFull && !doPop;

  // Event FIFO storage, pointers and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 10'd0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (doWrite) begin
        mem_q[wrPtr_q[AW-1:0]] <= {copCheck_q, copData_q};
        wrPtr_q                <= wrPtr_q + 1'b1;
      end
      if (doPop) rdPtr_q <= rdPtr_q + 1'b1;
      if (doDrop) overflow_q <= 1'b1;
    end
  end

  assign evt_valid = !fifoEmpty;
  assign evt_ch    = mem_q[rdPtr_q[AW-1:0]][9:8];
  assign evt_data  = mem_q[rdPtr_q[AW-1:0]][7:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sensor_scan_scheduler.sv
// Randomized bench for sensor_scan_scheduler against a scan-timeline model.
// The model tracks how many cycles have passed since the last grant and keeps
// the event log as a plain queue.

module tb_sensor_scan_scheduler;

  localparam int Hold  = 4;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  chValid = 4'd0;
  logic [31:0] chData = 32'd0;
  logic [3:0]  enMask = 4'd0;
  logic [3:0]  chAck;
  logic [7:0]  copData;
  logic [1:0]  copCheck;
  logic        copQ = 1'b0;
  logic [1:0]  copQ1 = 2'd0;
  logic        evtValid;
  logic [1:0]  evtCh;
  logic [7:0]  evtData;
  logic        evtReady = 1'b0;
  logic        overflow;
  logic        busy;

  int errCount = 0;
  int checkCount = 0;

  // Model: cycles since grant (0 = not scanning), last winner, held sample, event log.
  int         sinceGrant;
  int         lastWinner;
  logic [7:0] mData;
  logic [1:0] mCh;
  logic [9:0] eventLog[$];
  bit         mOverflow;
  logic [3:0] prevAck;
  int         readyPct;

  sensor_scan_scheduler #(.HOLD_CYCLES(Hold), .FIFO_DEPTH(Depth)) dut (
    .clk(clk), .rst_n(rst_n), .ch_valid(chValid), .ch_data(chData),
    .en_mask(enMask), .ch_ack(chAck), .cop_data(copData), .cop_check(copCheck),
    .cop_q(copQ), .cop_q1(copQ1), .evt_valid(evtValid), .evt_ch(evtCh),
    .evt_data(evtData), .evt_ready(evtReady), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickChannel(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic resetModel();
    sinceGrant = 0;
    lastWinner = 3;
    mData      = 8'd0;
    mCh        = 2'd0;
    eventLog.delete();
    mOverflow  = 1'b0;
    prevAck    = 4'd0;
  endtask

  // Drive one cycle of random inputs (called right after a falling edge).
  task automatic applyStimulus();
    chValid = chValid & ~prevAck;
    for (int c = 0; c < 4; c++) begin
      if (!chValid[c] && $urandom_range(0, 3) == 0) chValid[c] = 1'b1;
      enMask[c] = ($urandom_range(0, 4) != 0);
    end
    chData   = $urandom;
    copQ     = $urandom_range(0, 1);
    copQ1    = ($urandom_range(0, 1) == 1) ? mCh : 2'($urandom_range(0, 3));
    evtReady = ($urandom_range(0, 99) < readyPct);
  endtask

  // Compare outputs against the model, then advance the model across the next rising edge.
  task automatic checkAndStep();
    logic [3:0] req;
    logic [3:0] expAck;
    int         win;
    bit         isGrant, isCheck, pop, push, wasFull;

    req     = chValid & enMask;
    isGrant = (sinceGrant == 1);
    isCheck = (sinceGrant == Hold + 2);
    win     = pickChannel(req, lastWinner);
    expAck  = (isGrant && win >= 0) ? (4'b0001 << win) : 4'b0000;

    checkOutput("busy", busy, sinceGrant != 0);
    checkOutput("ch_ack", chAck, expAck);
    checkOutput("cop_data", copData, mData);
    checkOutput("cop_check", copCheck, mCh);
    checkOutput("evt_valid", evtValid, eventLog.size() != 0);
    checkOutput("overflow", overflow, mOverflow);
    if (eventLog.size() != 0) begin
      checkOutput("evt_ch", evtCh, eventLog[0][9:8]);
      checkOutput("evt_data", evtData, eventLog[0][7:0]);
    end

    wasFull = (eventLog.size() == Depth);
    pop     = (eventLog.size() != 0) && evtReady;
    push    = isCheck && copQ && (copQ1 == mCh);
    if (pop) void'(eventLog.pop_front());
    if (push) begin
      if (wasFull && !pop) mOverflow = 1'b1;
      else eventLog.push_back({mCh, mData});
    end

    if (sinceGrant == 0 || isCheck) begin
      sinceGrant = (req != 0) ? 1 : 0;
    end else if (isGrant) begin
      if (win >= 0) begin
        lastWinner = win;
        mCh        = 2'(win);
        mData      = chData[8*win +: 8];
        sinceGrant = 2;
      end else begin
        sinceGrant = 0;
      end
    end else begin
      sinceGrant++;
    end
    prevAck = expAck;
  endtask

  // Assert reset between edges so any scan in flight is abandoned.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ch_ack", chAck, 4'd0);
    checkOutput("rst_cop_data", copData, 8'd0);
    checkOutput("rst_cop_check", copCheck, 2'd0);
    checkOutput("rst_evt_valid", evtValid, 1'b0);
    checkOutput("rst_evt_ch", evtCh, 2'd0);
    checkOutput("rst_evt_data", evtData, 8'd0);
    checkOutput("rst_overflow", overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int pctTable[6] = '{30, 0, 90, 10, 60, 0};
    resetModel();
    @(negedge clk);
    for (int seg = 0; seg < 6; seg++) begin
      int cycles;
      doReset();
      readyPct = pctTable[seg];
      cycles = 700 + $urandom_range(0, 60);
      for (int n = 0; n < cycles; n++) begin
        applyStimulus();
        #1;
        checkAndStep();
        @(negedge clk);
      end
    end
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sensor_scan_scheduler.md
Name: sensor_scan_scheduler

Overview:
- Round-robin sequencer that shares the single change-detect co-processor between four sensor channels.
- Arbitrates among sensor channels that have a sample ready and drives the co-processor's sample/select inputs for a fixed hold window.
- Samples the co-processor's change flag and logs change events (channel, value) into a small event FIFO for the downstream LED/host logic.

Parameters:
HOLD_CYCLES, 4, cycles the selected sample is held on the co-processor inputs before the result is sampled; legal range 3..15, values below 3 are treated as 3.
FIFO_DEPTH, 4, event FIFO entries; must be a power of two, 2..8.

Ports:
clk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
ch_valid  input  4  per-channel sample ready; held until acked
ch_data  input  32  channel n sample on bits [8n+7:8n]
en_mask  input  4  per-channel scan enable; 0 = channel ignored
ch_ack  output  4  one-cycle pulse; sample of that channel consumed
cop_data  output  8  registered sample driven to co-processor
cop_check  output  2  registered channel select driven to co-processor
cop_q  input  1  co-processor change flag
cop_q1  input  2  co-processor changed-channel id
evt_valid  output  1  FIFO not empty
evt_ch  output  2  head event channel
evt_data  output  8  head event sample value
evt_ready  input  1  consumer pop; effective only when evt_valid=1
overflow  output  1  sticky; an event was dropped because the FIFO was full
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, ch_ack=0, cop_data=0, cop_check=0, FIFO empty (evt_valid=0, evt_ch=0, evt_data=0), overflow=0, busy=0, hold counter=0, RR pointer=3 (first grant goes to ch0). Reset mid-scan abandons the scan: no ack, no event.
- Request vector: req = ch_valid & en_mask.
- FSM states IDLE, GRANT, HOLD, CHECK.
- IDLE: if req!=0, go to GRANT next cycle; otherwise stay.
- GRANT, one cycle:
  - Pick the first set bit of req searching from ptr+1 upward, wrapping 3->0.
  - Register cop_check=ch and cop_data=ch_data[ch].
  - Pulse ch_ack[ch]=1 for this cycle only.
  - Set ptr=ch and load the hold counter with HOLD_CYCLES-1, then go to HOLD.
  - If req becomes 0 in this cycle (mask or valid dropped), return to IDLE with no ack and cop_* unchanged.
- HOLD: cop_* stay constant; decrement the counter each cycle; when counter==0, go to CHECK.
- CHECK, one cycle:
  - If cop_q=1 and cop_q1==cop_check, push {cop_check, cop_data}.
  - Otherwise push nothing. The co-processor reports ch0 with Q1=00 even when nothing changed, so cop_q gates the push.
  - Next state: GRANT if req!=0, else IDLE.
- Grant-to-check latency is HOLD_CYCLES+1 cycles. Minimum scan period is HOLD_CYCLES+2 cycles.
- en_mask changes take effect at the next GRANT. A channel masked during its own HOLD still completes its scan.
- FIFO:
  - Registered head outputs, show-ahead: evt_ch/evt_data are valid whenever evt_valid=1.
  - Pop occurs when evt_valid & evt_ready.
  - Push while full with no pop in the same cycle: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both happen, no drop.
  - Push and pop in the same cycle while empty: not possible (evt_valid=0).
  - Wrap-around: pointers of log2(FIFO_DEPTH)+1 bits.
  - overflow clears only on reset.
- busy=1 whenever FSM!=IDLE.

Test Plan:
- Reset then single request: ch_valid=0001, en_mask=1111, ch_data[7:0]=0x40, cop_q held 1 with cop_q1=00 -> ch_ack[0] pulses once at grant, cop_data=0x40, cop_check=0; with HOLD_CYCLES=4 CHECK occurs 5 cycles later; evt_valid=1, evt_ch=0, evt_data=0x40.
- Round-robin: all four valid continuously, cop_q=0 -> acks in order ch0,ch1,ch2,ch3,ch0 at a 6-cycle period; no events pushed.
- Masking: ch_valid=1111, en_mask=0101 -> only ch0 and ch2 are granted, alternating; ch_ack[1] and ch_ack[3] never pulse.
- Change filter: cop_q=1 with cop_q1=01 while cop_check=2 -> no push. cop_q=1 with cop_q1=10 -> push {2, data}.
- Overflow: FIFO_DEPTH=4, evt_ready=0, 5 qualifying scans -> evt_valid=1, 4 entries held in order, overflow=1 after the 5th. Then pop with evt_ready=1 -> entries 1..4 come out in order, and overflow stays 1.
- Async reset mid-HOLD: assert rst_n=0 at HOLD counter=2 -> all outputs zero immediately, FIFO empty. After release, the next grant goes to ch0.
